// File: rtl/fir_mac_csr_if.sv
// rtl/fir_mac_csr_if.sv - Register bus bundle for the FIR MAC accelerator
interface fir_mac_csr_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [4:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata, irq
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/fir_mac_csr.sv
// rtl/fir_mac_csr.sv - Memory-mapped FIR filter with programmable taps and a time-multiplexed MAC
module fir_mac_csr #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 8,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic         clk,
    input  logic         rst,
    fir_mac_csr_if.slave bus
);
    localparam int IDX_W = $clog2(TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] x    [TAPS];
    logic [COEF_W-1:0] coef [TAPS];
    logic [ACC_W-1:0]  acc;
    logic [IDX_W-1:0]  idx;
    logic              enable, sgn, irq_en, valid, overrun;
    logic [31:0]       result;

    logic              wr, rd, busy;
    logic              wr_ctrl, wr_status, wr_sample, rd_result;
    logic              valid_n, irq_en_n, overrun_n;
    logic [DATA_W-1:0] x_sel;
    logic [COEF_W-1:0] c_sel;
    logic [ACC_W-1:0]  x_ext, c_ext, prod;
    logic [31:0]       acc_ext, rdata;
    logic              unused_wdata;

    assign wr        = bus.chipselect & bus.write;
    assign rd        = bus.chipselect & bus.read;
    assign busy      = (state != IDLE);
    assign wr_ctrl   = wr && (bus.address == 5'd0);
    assign wr_status = wr && (bus.address == 5'd1);
    assign wr_sample = wr && (bus.address == 5'd2);
    assign rd_result = rd && (bus.address == 5'd3);
    assign unused_wdata = &{1'b0, bus.writedata};

    // Operands are widened to ACC_W before multiplying so the truncated
    // product is exact in both two's-complement and unsigned modes.
    assign x_sel   = x[idx];
    assign c_sel   = coef[idx];
    assign x_ext   = sgn ? ACC_W'($signed(x_sel)) : ACC_W'(x_sel);
    assign c_ext   = sgn ? ACC_W'($signed(c_sel)) : ACC_W'(c_sel);
    assign prod    = x_ext * c_ext;
    assign acc_ext = sgn ? 32'($signed(acc)) : 32'(acc);

    // A completion landing on the same edge as a RESULT read wins.
    assign valid_n   = (state == DONE) ? 1'b1 : (rd_result ? 1'b0 : valid);
    assign irq_en_n  = wr_ctrl ? bus.writedata[3] : irq_en;
    assign overrun_n = (wr_sample && enable && busy) ? 1'b1 :
                       ((wr_status && bus.writedata[2]) ? 1'b0 : overrun);

    always_comb begin
        rdata = '0;
        case (bus.address)
            5'd0: rdata = {28'd0, irq_en, 1'b0, sgn, enable};
            5'd1: rdata = {29'd0, overrun, valid, busy};
            5'd3: rdata = result;
            5'd4: rdata = {8'd0, 8'(ACC_W), 8'(COEF_W), 8'(TAPS)};
            default: begin
                for (int i = 0; i < TAPS; i++) begin
                    if (bus.address == 5'(16 + i)) rdata = 32'(coef[i]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            idx          <= '0;
            enable       <= 1'b0;
            sgn          <= 1'b0;
            irq_en       <= 1'b0;
            valid        <= 1'b0;
            overrun      <= 1'b0;
            result       <= '0;
            bus.readdata <= '0;
            bus.irq      <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x[i]    <= '0;
                coef[i] <= '0;
            end
        end else begin
            valid   <= valid_n;
            overrun <= overrun_n;
            irq_en  <= irq_en_n;
            bus.irq <= valid_n & irq_en_n;

            if (rd) bus.readdata <= rdata;

            if (wr_ctrl) begin
                enable <= bus.writedata[0];
                if (!busy) sgn <= bus.writedata[1];
            end

            if (wr && !busy) begin
                for (int i = 0; i < TAPS; i++) begin
                    if (bus.address == 5'(16 + i)) coef[i] <= bus.writedata[COEF_W-1:0];
                end
            end

            case (state)
                IDLE: begin
                    if (wr_sample && enable) begin
                        for (int i = TAPS - 1; i > 0; i--) x[i] <= x[i-1];
                        x[0]  <= bus.writedata[DATA_W-1:0];
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end else if (wr_ctrl && bus.writedata[2]) begin
                        for (int i = 0; i < TAPS; i++) x[i] <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    result <= acc_ext;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
